serial_frame_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-bit serial data line among NREQ requesters.
- Its d_out drives the d input of the downstream sampling flip-flop stage (the clk/d/q design).
- Each granted requester sends one FRAME_LEN-bit frame, LSB first, one bit per clk.
- Frames never interleave.

---
 rtl/serial_frame_arbiter.sv | 118 +++++++++++
 tb/tb_serial_frame_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_arbiter.sv
// Round-robin arbiter that shares one serial bit line among NREQ requesters.
// Each winner's FRAME_LEN-bit payload is shifted out LSB first, one bit per clk.
module serial_frame_arbiter #(
   parameter int NREQ      = 4,
   parameter int FRAME_LEN = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*FRAME_LEN-1:0] data,
   output logic [NREQ-1:0]           grant,
   output logic [NREQ-1:0]           done,
   output logic                      busy,
   output logic                      d_out
);

   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam int PTR_W = $clog2(NREQ);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
   localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NREQ - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [FRAME_LEN-1:0]   shreg, shreg_n;
   logic [PTR_W-1:0]       last, last_n;
   logic [NREQ-1:0]        owner, owner_n;
   logic [NREQ-1:0]        grant_n, done_n;
   logic                   busy_n, d_n;

   logic                   win_vld;
   logic [PTR_W-1:0]       win;
   logic [NREQ-1:0]        win_oh;
   logic [FRAME_LEN-1:0]   win_data;

   // Walk from the largest offset down so the requester closest after 'last' wins.
   always_comb begin
      win_vld = 1'b0;
      win     = last;
      for (int i = NREQ; i >= 1; i--) begin
         if (req[(int'(last) + i) % NREQ]) begin
            win_vld = 1'b1;
            win     = PTR_W'((int'(last) + i) % NREQ);
         end
      end
      win_oh   = NREQ'(1) << win;
      win_data = data[int'(win)*FRAME_LEN +: FRAME_LEN];
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      shreg_n = shreg;
      last_n  = last;
      owner_n = owner;
      grant_n = '0;
      done_n  = '0;
      busy_n  = busy;
      d_n     = d_out;
      case (state)
         IDLE: begin
            busy_n = 1'b0;
            d_n    = 1'b0;
            if (win_vld) begin
               shreg_n = win_data;
               last_n  = win;
               owner_n = win_oh;
               grant_n = win_oh;
               cnt_n   = '0;
               busy_n  = 1'b1;
               d_n     = win_data[0];
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == LAST_BIT) begin
               state_n = IDLE;
               cnt_n   = '0;
               busy_n  = 1'b0;
               d_n     = 1'b0;
            end else begin
               // shreg[0] is the bit currently on the line; the next one moves in.
               shreg_n = shreg >> 1;
               cnt_n   = cnt + CNT_W'(1);
               d_n     = shreg[1];
               if (cnt_n == LAST_BIT) done_n = owner;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         shreg <= '0;
         last  <= PTR_RST;
         owner <= '0;
         grant <= '0;
         done  <= '0;
         busy  <= 1'b0;
         d_out <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         shreg <= shreg_n;
         last  <= last_n;
         owner <= owner_n;
         grant <= grant_n;
         done  <= done_n;
         busy  <= busy_n;
         d_out <= d_n;
      end
   end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Scoreboard bench for serial_frame_arbiter: expected frames are queued when
// requests are driven and checked bit by bit as the DUT shifts them out.
module tb_serial_frame_arbiter;

   localparam int NREQ = 4;
   localparam int FL   = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ*FL-1:0]  data;
   logic [NREQ-1:0]     grant, done;
   logic                busy, d_out;

   serial_frame_arbiter #(.NREQ(NREQ), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .req(req), .data(data),
      .grant(grant), .done(done), .busy(busy), .d_out(d_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [FL-1:0] payload;
   } exp_t;

   exp_t   sb[$];
   exp_t   cur;
   int     gq[$];
   int     cyc = 0;
   int     done_cyc = 0;
   int     mbit = -1;
   int     nchk = 0;
   int     npass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: -1 idle, 0..FL-1 bit index of the current frame, -2 post-frame gap.
   always @(negedge clk) begin
      if (rst) begin
         mbit = -1;
      end else begin
         if (mbit == -1 && grant != 0) begin
            if (sb.size() == 0) begin
               chk("sb_empty_at_grant", 32'd0, 32'd1);
            end else begin
               cur = sb.pop_front();
               chk("grant", 32'(grant), 32'(1) << cur.id);
               gq.push_back(cyc);
               mbit = 0;
            end
         end else if (mbit >= 0) begin
            chk("grant_mid_frame", 32'(grant), 32'd0);
         end
         if (mbit >= 0) begin
            chk("d_out", 32'(d_out), 32'(cur.payload[mbit]));
            chk("busy", 32'(busy), 32'd1);
            chk("done", 32'(done), (mbit == FL-1) ? (32'(1) << cur.id) : 32'd0);
            if (done != 0) done_cyc = cyc;
            mbit++;
            if (mbit == FL) mbit = -2;
         end else if (mbit == -2) begin
            chk("gap_d_out", 32'(d_out), 32'd0);
            chk("gap_busy", 32'(busy), 32'd0);
            chk("gap_grant", 32'(grant), 32'd0);
            mbit = -1;
         end else begin
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_d_out", 32'(d_out), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
         end
      end
   end

   task automatic push_exp(input int id, input logic [FL-1:0] p);
      exp_t e;
      e.id = id;
      e.payload = p;
      sb.push_back(e);
   endtask

   task automatic wait_grant(input int idx);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!grant[idx] && n < 100);
      if (!grant[idx]) chk("grant_timeout", 32'(idx), 32'hFFFF);
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while ((sb.size() != 0 || mbit != -1) && n < 200);
      if (sb.size() != 0 || mbit != -1) chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req = '0; data = '0;
      #12;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_d_out", 32'(d_out), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // single request, A5 held for one edge
      data[0 +: FL] = 8'hA5; req = 4'b0001;
      push_exp(0, 8'hA5);
      @(posedge clk);
      #1 req = '0;
      drain();

      // simultaneous requests 1 and 3 after reset
      do_reset();
      gq.delete();
      data[1*FL +: FL] = 8'hFF; data[3*FL +: FL] = 8'h00; req = 4'b1010;
      push_exp(1, 8'hFF); push_exp(3, 8'h00);
      wait_grant(1); req[1] = 1'b0;
      wait_grant(3); req = '0;
      drain();
      if (gq.size() == 2) chk("pair_spacing", 32'(gq[1] - gq[0]), 32'd9);
      else chk("pair_grants", 32'(gq.size()), 32'd2);

      // all four requesting continuously
      do_reset();
      gq.delete();
      data = {8'h12, 8'h34, 8'h56, 8'h78}; req = 4'b1111;
      for (int i = 0; i < 5; i++) push_exp(i % NREQ, data[(i % NREQ)*FL +: FL]);
      for (int i = 0; i < 5; i++) wait_grant(i % NREQ);
      req = '0;
      drain();
      if (gq.size() == 5) begin
         for (int i = 0; i < 4; i++) chk("rr_spacing", 32'(gq[i+1] - gq[i]), 32'd9);
      end else chk("rr_grants", 32'(gq.size()), 32'd5);

      // payload changes after grant must not affect the frame
      data[2*FL +: FL] = 8'h0F; req = 4'b0100;
      push_exp(2, 8'h0F);
      wait_grant(2);
      data[2*FL +: FL] = 8'hF0; req = '0;
      drain();

      // reset at bit 4 aborts the frame
      data[0 +: FL] = 8'h3C; req = 4'b0001;
      push_exp(0, 8'h3C);
      wait_grant(0); req = '0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_d_out", 32'(d_out), 32'd0);
      chk("abort_grant", 32'(grant), 32'd0);
      @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      data[1*FL +: FL] = 8'h81; data[2*FL +: FL] = 8'h7E; req = 4'b0110;
      push_exp(1, 8'h81);
      wait_grant(1); req = '0;
      drain();

      // request raised mid-frame waits for the idle gap
      data[0 +: FL] = 8'h5A; req = 4'b0001;
      push_exp(0, 8'h5A);
      wait_grant(0); req = '0;
      repeat (3) @(posedge clk);
      #1 data[2*FL +: FL] = 8'hC3; req = 4'b0100;
      push_exp(2, 8'hC3);
      wait_grant(2);
      chk("done_to_grant", 32'(cyc - done_cyc), 32'd2);
      req = '0;
      drain();

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
